// File: rtl/alu_cmd_sequencer.sv
// ALU command sequencer: buffers commands in a FIFO, issues one at a time to the ALU and returns results in order.
// Optional feature macro: ALU_SEQ_ROT_BLOCK_EN (rejects rotate op 3'b111 with rsp_err instead of issuing it).
module alu_cmd_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [2:0]                   cmd_op,
  input  logic [DATA_WIDTH-1:0]        cmd_a,
  input  logic [DATA_WIDTH-1:0]        cmd_b,
  input  logic                         cmd_dir,
  input  logic                         cmd_bypass_a,
  input  logic                         cmd_bypass_b,
  output logic [2:0]                   alu_op,
  output logic [DATA_WIDTH-1:0]        alu_a,
  output logic [DATA_WIDTH-1:0]        alu_b,
  output logic                         alu_dir,
  output logic                         alu_bypass_a,
  output logic                         alu_bypass_b,
  input  logic [DATA_WIDTH-1:0]        alu_result_reg,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DATA_WIDTH-1:0]        rsp_data,
  output logic [2:0]                   rsp_op,
  output logic                         rsp_err,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t state_q, state_d;

  logic [2:0]            q_op [DEPTH];
  logic [DATA_WIDTH-1:0] q_a  [DEPTH];
  logic [DATA_WIDTH-1:0] q_b  [DEPTH];
  logic                  q_dir[DEPTH];
  logic                  q_ba [DEPTH];
  logic                  q_bb [DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          push, pop;
  logic          load_alu, capture, rot_rsp, rsp_done;
  logic          blk_rot;
  logic [2:0]    head_op;

  // cmd_ready depends only on registered occupancy, so a full FIFO refuses even on a pop cycle
  assign cmd_ready = (count != FULL_CNT);
  assign push      = cmd_valid && cmd_ready;
  assign head_op   = q_op[rd_ptr];
  assign busy      = (state_q != IDLE);

`ifdef ALU_SEQ_ROT_BLOCK_EN
  assign blk_rot = (head_op == 3'b111);
`else
  assign blk_rot = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      q_op[wr_ptr]  <= cmd_op;
      q_a[wr_ptr]   <= cmd_a;
      q_b[wr_ptr]   <= cmd_b;
      q_dir[wr_ptr] <= cmd_dir;
      q_ba[wr_ptr]  <= cmd_bypass_a;
      q_bb[wr_ptr]  <= cmd_bypass_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    load_alu = 1'b0;
    capture  = 1'b0;
    rot_rsp  = 1'b0;
    rsp_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (count != '0) begin
          pop = 1'b1;
          if (blk_rot) begin
            rot_rsp = 1'b1;
            state_d = RESP;
          end else begin
            load_alu = 1'b1;
            state_d  = ISSUE;
          end
        end
      end
      ISSUE:   state_d = CAPTURE;
      CAPTURE: begin
        capture = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ALU drive: loaded on pop, held through ISSUE, cleared once the result is captured
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_op       <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_dir      <= 1'b0;
      alu_bypass_a <= 1'b0;
      alu_bypass_b <= 1'b0;
    end else if (load_alu) begin
      alu_op       <= head_op;
      alu_a        <= q_a[rd_ptr];
      alu_b        <= q_b[rd_ptr];
      alu_dir      <= q_dir[rd_ptr];
      alu_bypass_a <= q_ba[rd_ptr];
      alu_bypass_b <= q_bb[rd_ptr];
    end else if (capture) begin
      alu_op       <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_dir      <= 1'b0;
      alu_bypass_a <= 1'b0;
      alu_bypass_b <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_op    <= '0;
    end else if (capture) begin
      rsp_valid <= 1'b1;
      rsp_data  <= alu_result_reg;
      rsp_op    <= alu_op;
    end else if (rot_rsp) begin
      rsp_valid <= 1'b1;
      rsp_data  <= '0;
      rsp_op    <= 3'b111;
    end else if (rsp_done) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef ALU_SEQ_ROT_BLOCK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          rsp_err <= 1'b0;
    else if (capture) rsp_err <= 1'b0;
    else if (rot_rsp) rsp_err <= 1'b1;
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule
